// File: rtl/dot_seq_ctrl.sv
`default_nettype none
// ============================================================================
// dot_seq_ctrl : read-issue and reduction-control sequencer for SIMD dot product
// Rev 1.0
// ============================================================================
module dot_seq_ctrl #(
  parameter int PE_COUNT   = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 8,
  parameter int PIPE_LAT   = 2
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          start,
  input  logic [$clog2(PE_COUNT):0]     cfg_rows,
  input  logic [LEN_WIDTH-1:0]          cfg_chunks,
  input  logic [ADDR_WIDTH-1:0]         cfg_base_a,
  input  logic [ADDR_WIDTH-1:0]         cfg_base_b,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic                          rd_en,
  output logic [ADDR_WIDTH-1:0]         rd_addr_a,
  output logic [ADDR_WIDTH-1:0]         rd_addr_b,
  output logic                          dp_clr_n,
  output logic                          dot_prod_en,
  output logic                          shift
);

  localparam int RW = $clog2(PE_COUNT) + 1;
  localparam int PW = LEN_WIDTH + RW;
  localparam int DW = $clog2(PIPE_LAT + 1);
  localparam logic [RW-1:0] MAX_ROWS  = RW'(PE_COUNT);
  localparam logic [DW-1:0] DRAIN_END = DW'(PIPE_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_ISSUE = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                 state_q;
  logic [RW-1:0]          rows_q;
  logic [LEN_WIDTH-1:0]   chunks_q;
  logic [ADDR_WIDTH-1:0]  base_a_q;
  logic [ADDR_WIDTH-1:0]  base_b_q;
  logic [RW-1:0]          row_q;
  logic [LEN_WIDTH-1:0]   chunk_q;
  logic [DW-1:0]          drain_q;
  logic                   rd_en_q;
  logic                   first_q;
  logic [ADDR_WIDTH-1:0]  addr_a_q;
  logic [ADDR_WIDTH-1:0]  addr_b_q;
  logic                   clr_n_q;
  logic                   done_q;
  logic                   err_q;
  logic [PIPE_LAT-1:0]    dl_en_q;
  logic [PIPE_LAT-1:0]    dl_sh_q;

  logic                   cfg_ok;
  logic                   last_chunk;
  logic                   last_issue;
  logic [RW-1:0]          row_d;
  logic [LEN_WIDTH-1:0]   chunk_d;
  logic [PW-1:0]          offs_d;
  logic [ADDR_WIDTH-1:0]  addr_a_d;
  logic [ADDR_WIDTH-1:0]  addr_b_d;

  assign cfg_ok     = (cfg_rows != '0) && (cfg_rows <= MAX_ROWS) && (cfg_chunks != '0);
  assign last_chunk = (chunk_q == chunks_q - LEN_WIDTH'(1));
  assign last_issue = last_chunk && (row_q == rows_q - RW'(1));

  // Offset row*C+chunk is formed at full width, then wrapped into the address space
  always_comb begin
    row_d   = row_q;
    chunk_d = chunk_q + LEN_WIDTH'(1);
    if (last_chunk) begin
      row_d   = row_q + RW'(1);
      chunk_d = '0;
    end
    offs_d   = PW'(row_d) * PW'(chunks_q) + PW'(chunk_d);
    addr_a_d = base_a_q + ADDR_WIDTH'(offs_d);
    addr_b_d = base_b_q + ADDR_WIDTH'(chunk_d);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      rows_q   <= '0;
      chunks_q <= '0;
      base_a_q <= '0;
      base_b_q <= '0;
      row_q    <= '0;
      chunk_q  <= '0;
      drain_q  <= '0;
      rd_en_q  <= 1'b0;
      first_q  <= 1'b0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      clr_n_q  <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      dl_en_q  <= '0;
      dl_sh_q  <= '0;
    end else begin
      err_q <= 1'b0;
      // Delay line aligns each issue with its arrival at the reduction stage
      for (int i = PIPE_LAT - 1; i > 0; i--) begin
        dl_en_q[i] <= dl_en_q[i-1];
        dl_sh_q[i] <= dl_sh_q[i-1];
      end
      dl_en_q[0] <= rd_en_q;
      dl_sh_q[0] <= rd_en_q & first_q;

      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              rows_q   <= cfg_rows;
              chunks_q <= cfg_chunks;
              base_a_q <= cfg_base_a;
              base_b_q <= cfg_base_b;
              clr_n_q  <= 1'b0;
              state_q  <= S_CLEAR;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_CLEAR: begin
          clr_n_q  <= 1'b1;
          rd_en_q  <= 1'b1;
          first_q  <= 1'b1;
          row_q    <= '0;
          chunk_q  <= '0;
          addr_a_q <= base_a_q;
          addr_b_q <= base_b_q;
          state_q  <= S_ISSUE;
        end
        S_ISSUE: begin
          if (last_issue) begin
            rd_en_q <= 1'b0;
            first_q <= 1'b0;
            drain_q <= '0;
            state_q <= S_DRAIN;
          end else begin
            row_q    <= row_d;
            chunk_q  <= chunk_d;
            first_q  <= (chunk_d == '0);
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
          end
        end
        S_DRAIN: begin
          if (drain_q == DRAIN_END) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            drain_q <= drain_q + DW'(1);
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign err         = err_q;
  assign rd_en       = rd_en_q;
  assign rd_addr_a   = addr_a_q;
  assign rd_addr_b   = addr_b_q;
  assign dp_clr_n    = clr_n_q;
  assign dot_prod_en = dl_en_q[PIPE_LAT-1];
  assign shift       = dl_sh_q[PIPE_LAT-1];

endmodule
`default_nettype wire

// File: doc/dot_seq_ctrl.md
Name: dot_seq_ctrl

Overview:
Sequencer for the SIMD dot-product reduction datapath. It accepts a job of R output rows, each reduced over C chunks of PE_COUNT elements. It issues one operand-pair read per cycle, then drives the reduction stage's enable and shift controls after a fixed pipeline delay, so that each row lands in its own output slot. It sits between the host command interface, the operand memories, and the PE array / reduction stage.

Parameters:
PE_COUNT, 4, number of PE lanes and number of output slots (power of two, >=2)
ADDR_WIDTH, 8, operand memory word-address width
LEN_WIDTH, 8, width of the chunks-per-row field
PIPE_LAT, 2, cycles from read issue to reduction-stage input (memory read latency plus PE latency, >=1)

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-low
start  in  1  job request; sampled only in IDLE
cfg_rows  in  $clog2(PE_COUNT)+1  output rows R, legal range 1..PE_COUNT
cfg_chunks  in  LEN_WIDTH  chunks per row C, legal range >=1
cfg_base_a  in  ADDR_WIDTH  matrix base word address (row-major, in chunk words)
cfg_base_b  in  ADDR_WIDTH  vector base word address
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse at job completion
err  out  1  one-cycle pulse when start is rejected for illegal config
rd_en  out  1  operand read strobe
rd_addr_a  out  ADDR_WIDTH  matrix operand address
rd_addr_b  out  ADDR_WIDTH  vector operand address
dp_clr_n  out  1  active-low clear of the reduction stage's slot index/accumulators
dot_prod_en  out  1  reduction-stage enable
shift  out  1  reduction-stage "open new slot" control

Behaviour:
- Reset (rstn=0 at a clk edge): state IDLE, all counters 0, delay line cleared; busy=0, done=0, err=0, rd_en=0, dot_prod_en=0, shift=0, dp_clr_n=1, address outputs 0. Reset mid-job aborts immediately; no done pulse is produced.
- States: IDLE, CLEAR, ISSUE, DRAIN, DONE.
- IDLE, start=1, config legal: latch cfg_* and go to CLEAR.
- IDLE, start=1, illegal config (R=0, R>PE_COUNT, or C=0): err=1 for the next cycle, stay IDLE, no other output changes.
- start outside IDLE is ignored; config is not re-sampled.
- CLEAR (1 cycle): dp_clr_n=0, then go to ISSUE.
- ISSUE (exactly R*C cycles, one read per cycle):
  - rd_en=1, rd_addr_a=base_a+row*C+chunk, rd_addr_b=base_b+chunk.
  - Addresses use modulo 2^ADDR_WIDTH arithmetic.
  - chunk counts 0..C-1, then wraps to 0 and row increments.
  - The issue flag "first" = (chunk==0) and en=1 enter a PIPE_LAT-deep delay line.
  - After the issue of row R-1, chunk C-1, go to DRAIN.
- DRAIN (exactly PIPE_LAT cycles): rd_en=0; the delay line keeps shifting. Then go to DONE.
- DONE (1 cycle): done=1, then go to IDLE. A new start is accepted only from the following IDLE cycle.
- Delay line output: dot_prod_en = delayed en; shift = delayed en & delayed first. Outside the delay window both are 0.
- Per row, the output is exactly one shift-pulse cycle followed by C-1 accumulate cycles.
- Timing, with start accepted at cycle 0 and N=R*C:
  - CLEAR at cycle 1.
  - Issues at cycles 2..N+1.
  - dot_prod_en at cycles 2+PIPE_LAT..N+1+PIPE_LAT.
  - done at cycle N+2+PIPE_LAT.
- C=1: every dot_prod_en cycle also has shift=1.
- Internal row*C product is full width (LEN_WIDTH+row bits) before truncation to ADDR_WIDTH.

Test Plan:
- Reset then idle: rstn low 3 cycles, start=0 -> all outputs at reset values; busy=0; dp_clr_n=1.
- Basic job, PIPE_LAT=2, R=2, C=3, base_a=0x10, base_b=0x40, start at cycle 0:
  - dp_clr_n=0 at cycle 1.
  - rd_addr_a = 10,11,12,13,14,15 and rd_addr_b = 40,41,42,40,41,42 at cycles 2..7.
  - dot_prod_en at cycles 4..9 with shift pattern 1,0,0,1,0,0.
  - done at cycle 10; busy 1..10.
- Single-chunk rows, R=4, C=1 -> shift=1 on all 4 dot_prod_en cycles; done at cycle 8.
- Illegal config: start with R=0, then start with R=5 (PE_COUNT=4), then start with C=0 -> err pulse after each; busy stays 0; no reads issued.
- start pulsed during ISSUE and during DONE -> ignored. start in the cycle after done -> new job begins with CLEAR.
- Address wrap: base_a=0xFE, R=1, C=4 -> rd_addr_a = FE, FF, 00, 01.
- Reset mid-job: rstn=0 during ISSUE -> next cycle all outputs at reset values; no done pulse; delay line empty (no stray dot_prod_en).
